// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity constants and parity helper for uart_duplex
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 8;

    // Payload is zero-extended to MAX_DATA_BITS; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_duplex_if.sv
// rtl/uart_duplex_if.sv - byte-side TX request and RX delivery bundle of uart_duplex
interface uart_duplex_if #(
    parameter int data_bits = 8
);
    logic [data_bits-1:0] tx_data;
    logic                 tx_req;
    logic                 tx_ready;
    logic [data_bits-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_req,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_req,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_duplex_rx.sv
// rtl/uart_duplex_rx.sv - receive path: two-flop synchroniser and mid-bit sampling RX FSM
module uart_duplex_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4,
    parameter int data_bits      = 8,
    parameter int parity_mode    = PAR_NONE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_line,
    output logic [data_bits-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err
);

    localparam int TW = $clog2(clocks_per_bit);
    localparam int BW = $clog2(data_bits + 1);
    localparam logic [TW-1:0] T_FULL     = TW'(clocks_per_bit - 1);
    localparam logic [TW-1:0] T_HALF     = TW'(clocks_per_bit / 2 - 1);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [BW-1:0] B_LAST     = BW'(data_bits - 1);
    localparam logic [BW-1:0] B_ONE      = BW'(1);
    localparam logic          HAS_PARITY = (parity_mode != PAR_NONE);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_sync;
    uart_state_t          r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit;
    logic [data_bits-1:0] r_shift;
    logic                 r_par_sample;
    logic [data_bits-1:0] r_data;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync = r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_sample <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_sync) begin
                        r_state <= START;
                        r_timer <= T_HALF;
                    end
                end
                START: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - T_ONE;
                    end else if (w_sync) begin
                        // Line went back high before mid start bit: treat as a glitch.
                        r_state <= IDLE;
                    end else begin
                        r_state <= DATA;
                        r_timer <= T_FULL;
                        r_bit   <= '0;
                    end
                end
                DATA: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - T_ONE;
                    end else begin
                        r_shift <= {w_sync, r_shift[data_bits-1:1]};
                        r_timer <= T_FULL;
                        if (r_bit == B_LAST) begin
                            r_state <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + B_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - T_ONE;
                    end else begin
                        r_par_sample <= w_sync;
                        r_state      <= STOP;
                        r_timer      <= T_FULL;
                    end
                end
                STOP: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - T_ONE;
                    end else begin
                        // Leave mid stop bit so a start bit straight after it is caught.
                        r_data       <= r_shift;
                        r_valid      <= 1'b1;
                        r_frame_err  <= ~w_sync;
                        r_parity_err <= HAS_PARITY &&
                            (r_par_sample != calc_parity(MAX_DATA_BITS'(r_shift), parity_mode));
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_duplex.sv
// rtl/uart_duplex.sv - full-duplex UART top: inline TX FSM, loopback mux and RX sub-module
module uart_duplex
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4,
    parameter int data_bits      = 8,
    parameter int parity_mode    = PAR_NONE,
    parameter int stop_bits      = 1
) (
    input  logic          i_ser_clk,
    input  logic          i_rst,
    uart_duplex_if.slave  io_bus,
    output logic          o_ser_tx,
    input  logic          i_ser_rx,
    input  logic          i_loopback
);

    if (clocks_per_bit < 4) begin : g_cpb_check
        $error("uart_duplex: clocks_per_bit must be >= 4");
    end
    if (data_bits < 5 || data_bits > 8) begin : g_db_check
        $error("uart_duplex: data_bits must be 5..8");
    end
    if (stop_bits < 1 || stop_bits > 2) begin : g_sb_check
        $error("uart_duplex: stop_bits must be 1 or 2");
    end

    localparam int TW = $clog2(clocks_per_bit);
    localparam int BW = $clog2(data_bits + 1);
    localparam logic [TW-1:0] T_FULL      = TW'(clocks_per_bit - 1);
    localparam logic [TW-1:0] T_ONE       = TW'(1);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(data_bits - 1);
    localparam logic [BW-1:0] B_LAST_STOP = BW'(stop_bits - 1);
    localparam logic [BW-1:0] B_ONE       = BW'(1);
    localparam logic          HAS_PARITY  = (parity_mode != PAR_NONE);

    uart_state_t          r_tx_state;
    logic [TW-1:0]        r_tx_timer;
    logic [BW-1:0]        r_tx_bit;
    logic [data_bits-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_ser_tx;
    logic                 r_tx_ready;
    logic                 w_accept;
    logic                 w_rx_line;

    assign w_accept = io_bus.tx_req && r_tx_ready;

    always_ff @(posedge i_ser_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_ser_tx   <= 1'b1;
            r_tx_ready <= 1'b1;
        end else if (w_accept) begin
            // Ready is only high in IDLE or the final STOP cycle, so this covers both.
            r_tx_state <= START;
            r_tx_timer <= T_FULL;
            r_tx_bit   <= '0;
            r_tx_shift <= io_bus.tx_data;
            r_tx_par   <= calc_parity(MAX_DATA_BITS'(io_bus.tx_data), parity_mode);
            r_ser_tx   <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    r_ser_tx   <= 1'b1;
                    r_tx_ready <= 1'b1;
                end
                START: begin
                    if (r_tx_timer != '0) begin
                        r_tx_timer <= r_tx_timer - T_ONE;
                    end else begin
                        r_tx_state <= DATA;
                        r_tx_timer <= T_FULL;
                        r_ser_tx   <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                DATA: begin
                    if (r_tx_timer != '0) begin
                        r_tx_timer <= r_tx_timer - T_ONE;
                    end else begin
                        r_tx_timer <= T_FULL;
                        if (r_tx_bit == B_LAST_DATA) begin
                            r_tx_bit <= '0;
                            if (HAS_PARITY) begin
                                r_tx_state <= PARITY;
                                r_ser_tx   <= r_tx_par;
                            end else begin
                                r_tx_state <= STOP;
                                r_ser_tx   <= 1'b1;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + B_ONE;
                            r_ser_tx   <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (r_tx_timer != '0) begin
                        r_tx_timer <= r_tx_timer - T_ONE;
                    end else begin
                        r_tx_state <= STOP;
                        r_tx_timer <= T_FULL;
                        r_tx_bit   <= '0;
                        r_ser_tx   <= 1'b1;
                    end
                end
                STOP: begin
                    if (r_tx_timer != '0) begin
                        r_tx_timer <= r_tx_timer - T_ONE;
                        if (r_tx_timer == T_ONE && r_tx_bit == B_LAST_STOP) begin
                            r_tx_ready <= 1'b1;
                        end
                    end else if (r_tx_bit == B_LAST_STOP) begin
                        r_tx_state <= IDLE;
                    end else begin
                        r_tx_bit   <= r_tx_bit + B_ONE;
                        r_tx_timer <= T_FULL;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    assign o_ser_tx        = r_ser_tx;
    assign io_bus.tx_ready = r_tx_ready;
    assign w_rx_line       = i_loopback ? r_ser_tx : i_ser_rx;

    uart_duplex_rx #(
        .clocks_per_bit (clocks_per_bit),
        .data_bits      (data_bits),
        .parity_mode    (parity_mode)
    ) u_rx (
        .i_clk        (i_ser_clk),
        .i_rst        (i_rst),
        .i_line       (w_rx_line),
        .o_data       (io_bus.rx_data),
        .o_valid      (io_bus.rx_valid),
        .o_parity_err (io_bus.rx_parity_err),
        .o_frame_err  (io_bus.rx_frame_err)
    );

endmodule
